// File: rtl/inert_serf_pkg.sv
// Shared types and register map for the inertial-sensor SPI serf.
package inert_serf_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int FRAME_BITS = 16;
  localparam int CMD_BITS   = 8;

  localparam logic [7:0] INT_EN_VAL = 8'h02;

  localparam logic [6:0] ADDR_INT_CFG = 7'h0D;
  localparam logic [6:0] ADDR_WHOAMI  = 7'h0F;
  localparam logic [6:0] ADDR_CFG_10  = 7'h10;
  localparam logic [6:0] ADDR_CFG_11  = 7'h11;
  localparam logic [6:0] ADDR_CFG_14  = 7'h14;
  localparam logic [6:0] ADDR_PTCH_L  = 7'h22;
  localparam logic [6:0] ADDR_PTCH_H  = 7'h23;
  localparam logic [6:0] ADDR_ROLL_L  = 7'h24;
  localparam logic [6:0] ADDR_ROLL_H  = 7'h25;
  localparam logic [6:0] ADDR_YAW_L   = 7'h26;
  localparam logic [6:0] ADDR_YAW_H   = 7'h27;
  localparam logic [6:0] ADDR_AX_L    = 7'h28;
  localparam logic [6:0] ADDR_AX_H    = 7'h29;
  localparam logic [6:0] ADDR_AY_L    = 7'h2A;
  localparam logic [6:0] ADDR_AY_H    = 7'h2B;

endpackage

// File: rtl/spi_serf_shft.sv
// SPI serf framing: input synchronizers, SCLK/SS_n edge detect, rx/tx shifters.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | SS_n high (synced); waiting for select to fall
// SHIFT | frame in progress; shifting on SCLK edges until SS_n rises
module spi_serf_shft
  import inert_serf_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ss_n,
  input  logic        sclk,
  input  logic        mosi,
  input  logic [7:0]  rd_byte,
  output logic        miso,
  output logic        busy,
  output logic        cmd_rdy,
  output logic        frm_done,
  output logic [15:0] rx_word
);

  logic [2:0]  ss_sync;
  logic [2:0]  sclk_sync;
  logic [1:0]  mosi_sync;
  logic        ss_fall, ss_rise, sclk_rise, sclk_fall, mosi_s;
  state_t      state, state_nxt;
  logic        frm_start, frm_end;
  logic [15:0] rx_shft, tx_shft;
  logic [4:0]  bit_cnt;

  // Double-flop the async SPI pins; a third SS_n/SCLK flop gives edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_sync   <= 3'b111;
      sclk_sync <= 3'b111;
      mosi_sync <= 2'b00;
    end else begin
      ss_sync   <= {ss_sync[1:0], ss_n};
      sclk_sync <= {sclk_sync[1:0], sclk};
      mosi_sync <= {mosi_sync[0], mosi};
    end
  end

  assign ss_fall   = ss_sync[2] & ~ss_sync[1];
  assign ss_rise   = ~ss_sync[2] & ss_sync[1];
  assign sclk_rise = ~sclk_sync[2] & sclk_sync[1];
  assign sclk_fall = sclk_sync[2] & ~sclk_sync[1];
  assign mosi_s    = mosi_sync[1];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and frame start/end strobes.
  always_comb begin
    state_nxt = state;
    frm_start = 1'b0;
    frm_end   = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall) begin
          state_nxt = SHIFT;
          frm_start = 1'b1;
        end
      end
      SHIFT: begin
        if (ss_rise) begin
          state_nxt = IDLE;
          frm_end   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shifters and bit counter. The read byte is loaded one clk after the 8th rise,
  // once the address byte is stable in rx_shft; the next SCLK fall presents bit 7.
  // frm_done is registered so the commit lands on the first IDLE clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_shft  <= '0;
      tx_shft  <= '0;
      bit_cnt  <= '0;
      miso     <= 1'b0;
      cmd_rdy  <= 1'b0;
      frm_done <= 1'b0;
    end else begin
      miso     <= tx_shft[15];
      cmd_rdy  <= 1'b0;
      frm_done <= frm_end && (bit_cnt == 5'(FRAME_BITS));
      if (frm_start) begin
        rx_shft <= '0;
        tx_shft <= '0;
        bit_cnt <= '0;
      end else if (state == SHIFT && !frm_end) begin
        if (sclk_rise) begin
          rx_shft <= {rx_shft[14:0], mosi_s};
          if (bit_cnt != 5'h1F) bit_cnt <= bit_cnt + 5'd1;
          cmd_rdy <= (bit_cnt == 5'(CMD_BITS - 1));
        end
        if (sclk_fall) tx_shft <= {tx_shft[14:0], 1'b0};
        if (cmd_rdy) tx_shft <= rx_shft[7] ? {1'b0, rd_byte, 7'b0} : 16'h0000;
      end
    end
  end

  assign busy    = (state == SHIFT);
  assign rx_word = rx_shft;

endmodule

// File: rtl/inert_sensor_serf.sv
// Inertial-sensor SPI serf: register map, sample capture with mid-frame deferral, INT.
module inert_sensor_serf
  import inert_serf_pkg::*;
#(
  parameter logic [7:0] WHOAMI = 8'h6A
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic        INT,
  input  logic        smpl_vld,
  input  logic [15:0] ptch_rt_in,
  input  logic [15:0] roll_rt_in,
  input  logic [15:0] yaw_rt_in,
  input  logic [15:0] ax_in,
  input  logic [15:0] ay_in,
  output logic        int_en
);

  logic        busy, cmd_rdy, frm_done;
  logic [15:0] rx_word;
  logic [7:0]  rd_byte, rd_mux;
  logic [7:0]  int_cfg, cfg_10, cfg_11, cfg_14;
  logic [15:0] ptch, roll, yaw, ax, ay;
  logic        pend;
  logic [79:0] pend_buf;
  logic [6:0]  cmt_addr;
  logic [7:0]  cmt_data;
  logic        wr_cmt, rd_cmt;
  logic        apply_new, apply_pend, int_set, int_rd_clr, int_wr_clr;

  spi_serf_shft u_shft (
    .clk      (clk),
    .rst_n    (rst_n),
    .ss_n     (SS_n),
    .sclk     (SCLK),
    .mosi     (MOSI),
    .rd_byte  (rd_byte),
    .miso     (MISO),
    .busy     (busy),
    .cmd_rdy  (cmd_rdy),
    .frm_done (frm_done),
    .rx_word  (rx_word)
  );

  assign cmt_addr = rx_word[14:8];
  assign cmt_data = rx_word[7:0];
  assign wr_cmt   = frm_done & ~rx_word[15];
  assign rd_cmt   = frm_done & rx_word[15];
  assign int_en   = (int_cfg == INT_EN_VAL);

  // A fresh strobe outranks a deferred one (newest sample wins).
  assign apply_new  = smpl_vld & int_en & ~busy;
  assign apply_pend = pend & int_en & ~busy & ~smpl_vld;
  assign int_set    = apply_new | apply_pend;
  assign int_rd_clr = rd_cmt & (cmt_addr == ADDR_YAW_H);
  assign int_wr_clr = wr_cmt & (cmt_addr == ADDR_INT_CFG) & (cmt_data != INT_EN_VAL);

  // Writable config registers, updated on commit of a complete write frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_cfg <= '0;
      cfg_10  <= '0;
      cfg_11  <= '0;
      cfg_14  <= '0;
    end else if (wr_cmt) begin
      case (cmt_addr)
        ADDR_INT_CFG: int_cfg <= cmt_data;
        ADDR_CFG_10:  cfg_10  <= cmt_data;
        ADDR_CFG_11:  cfg_11  <= cmt_data;
        ADDR_CFG_14:  cfg_14  <= cmt_data;
        default: ;
      endcase
    end
  end

  // Holding buffer for samples that arrive while a frame is being shifted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend     <= 1'b0;
      pend_buf <= '0;
    end else if (busy) begin
      if (smpl_vld && int_en) begin
        pend     <= 1'b1;
        pend_buf <= {ptch_rt_in, roll_rt_in, yaw_rt_in, ax_in, ay_in};
      end
    end else begin
      pend <= 1'b0;
    end
  end

  // Latched data copy read by the monarch; only updated outside a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {ptch, roll, yaw, ax, ay} <= '0;
    end else if (apply_new) begin
      {ptch, roll, yaw, ax, ay} <= {ptch_rt_in, roll_rt_in, yaw_rt_in, ax_in, ay_in};
    end else if (apply_pend) begin
      {ptch, roll, yaw, ax, ay} <= pend_buf;
    end
  end

  // INT: disabling via INT_CFG always clears; otherwise a new sample beats a yaw-H read clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          INT <= 1'b0;
    else if (int_wr_clr) INT <= 1'b0;
    else if (int_set)    INT <= 1'b1;
    else if (int_rd_clr) INT <= 1'b0;
  end

  // Read mux addressed by the command byte held in the low half of rx_word at cmd_rdy.
  always_comb begin
    rd_mux = 8'h00;
    case (rx_word[6:0])
      ADDR_INT_CFG: rd_mux = int_cfg;
      ADDR_WHOAMI:  rd_mux = WHOAMI;
      ADDR_CFG_10:  rd_mux = cfg_10;
      ADDR_CFG_11:  rd_mux = cfg_11;
      ADDR_CFG_14:  rd_mux = cfg_14;
      ADDR_PTCH_L:  rd_mux = ptch[7:0];
      ADDR_PTCH_H:  rd_mux = ptch[15:8];
      ADDR_ROLL_L:  rd_mux = roll[7:0];
      ADDR_ROLL_H:  rd_mux = roll[15:8];
      ADDR_YAW_L:   rd_mux = yaw[7:0];
      ADDR_YAW_H:   rd_mux = yaw[15:8];
      ADDR_AX_L:    rd_mux = ax[7:0];
      ADDR_AX_H:    rd_mux = ax[15:8];
      ADDR_AY_L:    rd_mux = ay[7:0];
      ADDR_AY_H:    rd_mux = ay[15:8];
      default:      rd_mux = 8'h00;
    endcase
  end

  assign rd_byte = cmd_rdy ? rd_mux : 8'h00;

endmodule
